instr_fetch: RTL and testbench

- Fetch stage directly upstream of the execute block.
- Holds the program counter and issues sequential reads to the instruction memory, which has a fixed 1-cycle read latency.
- Buffers returned 32-bit words in a 2-entry queue and presents them to execute as the IR value through a valid/ready handshake.
- Accepts a redirect (jump/branch) from downstream, which flushes everything in flight.

---
 rtl/instr_fetch.sv | 187 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage feeding the execute block. It holds the program counter and
//   issues sequential word reads to an instruction memory with a fixed
//   one-cycle read latency. Returned words land in a two-entry queue and are
//   presented to execute as the IR through a valid/ready handshake. A
//   redirect from downstream flushes everything in flight and restarts fetch.
//
//   Optional build macro: FETCH_HALT_DETECT_EN
//     When defined, a returned word whose oper field [31:27] is 5'b11111 is
//     queued normally. Fetch then stops in HALTED until a redirect or reset.
//     When undefined, that opcode is an ordinary instruction.
//
// Ports
//   clk          in   1       system clock, rising-edge
//   rst_n        in   1       synchronous active-low reset
//   run          in   1       fetch enable (0 = no new requests)
//   imem_req     out  1       instruction memory read strobe
//   imem_addr    out  ADDR_W  word address of the current request
//   imem_rdata   in   IW      read data, valid one cycle after imem_req
//   ir_out       out  IW      instruction at the queue head
//   ir_pc        out  ADDR_W  address ir_out was fetched from
//   ir_valid     out  1       queue head holds a valid instruction
//   ir_ready     in   1       execute consumes the head when ir_valid=1
//   redirect     in   1       flush and restart fetch
//   redirect_pc  in   ADDR_W  new PC, sampled when redirect=1
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                IW       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [IW-1:0]     imem_rdata,
    output logic [IW-1:0]     ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_FULL   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;      // address of the request in flight
    logic              r_inflight;
    logic              r_epoch;       // toggled on every redirect
    logic              r_req_epoch;   // epoch the in-flight request belongs to

    logic [IW-1:0]     r_q_data [2];  // entry 0 is the head
    logic [ADDR_W-1:0] r_q_pc   [2];
    logic [1:0]        r_occ;

    logic              w_pop;
    logic              w_push;
    logic              w_halt_hit;
    logic              w_req;
    logic [2:0]        w_pending;
    logic [1:0]        w_occ_nxt;
    logic [1:0]        w_slot;

    // A redirect kills the head, so a same-cycle ir_ready is not a pop.
    assign w_pop  = (r_occ != 2'd0) & ir_ready & ~redirect;

    // Responses are accepted only if they belong to the current epoch and no
    // redirect is flushing the queue this cycle.
    assign w_push = r_inflight & (r_req_epoch == r_epoch) & ~redirect;

`ifdef FETCH_HALT_DETECT_EN
    assign w_halt_hit = w_push & (imem_rdata[IW-1 -: 5] == 5'b11111);
`else
    assign w_halt_hit = 1'b0;
`endif

    // Slots that would be committed after this cycle's pop; a new request
    // is only safe while that stays below the queue depth.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Reset gates the strobe so the memory sees no reads while held in reset.
    // The halt word's arrival cycle also blocks issue, so nothing past the
    // halt word is ever requested.
    assign w_req = rst_n & run & ~redirect & (r_state != S_HALTED)
                 & ~w_halt_hit & (w_pending < 3'd2);

    // Tail position for a push, taking a simultaneous pop into account.
    assign w_slot = r_occ - {1'b0, w_pop};

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign ir_out    = r_q_data[0];
    assign ir_pc     = r_q_pc[0];
    assign ir_valid  = (r_occ != 2'd0);

    // Next queue occupancy.
    always_comb begin
        w_occ_nxt = r_occ;
        if (redirect) begin
            w_occ_nxt = 2'd0;
        end else begin
            w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Next fetch state; redirect dominates, HALTED is sticky otherwise.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = run ? S_FETCH : S_IDLE;
        end else if ((r_state == S_HALTED) || w_halt_hit) begin
            w_state_nxt = S_HALTED;
        end else if (w_occ_nxt == 2'd2) begin
            w_state_nxt = S_FULL;
        end else if (run) begin
            w_state_nxt = S_FETCH;
        end else begin
            w_state_nxt = S_IDLE;
        end
    end

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Program counter, in-flight tracking and flush epoch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_inflight  <= 1'b0;
            r_epoch     <= 1'b0;
            r_req_epoch <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (redirect) begin
                r_pc    <= redirect_pc;
                r_epoch <= ~r_epoch;
            end else if (w_req) begin
                r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (w_req) begin
                r_req_pc    <= r_pc;
                r_req_epoch <= r_epoch;
            end
        end
    end

    // Two-entry shift queue: pop shifts entry 1 to the head, push writes the
    // tail slot. A push into slot 0 after a pop overrides the shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ       <= 2'd0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_pop) begin
                r_q_data[0] <= r_q_data[1];
                r_q_pc[0]   <= r_q_pc[1];
            end
            if (w_push) begin
                r_q_data[w_slot[0]] <= imem_rdata;
                r_q_pc[w_slot[0]]   <= r_req_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ir_out;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    int vectors;
    int miscompares;
    bit halt_mode;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: 0x1000_0000 + address, with an optional halt word at 3.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (halt_mode && a == 16'h0003) return 32'hF800_0000;
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    // One-cycle-latency instruction memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        halt_mode = 1'b0;
        rst_n = 1'b0;
        run = 1'b1;
        ir_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        imem_rdata = 32'h0;

        // ---- Reset state and streaming ----
        tick();
        tick();
        #1;
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_addr",  {16'b0, imem_addr}, 32'd0);
        chk("rst_valid", {31'b0, ir_valid}, 32'd0);
        chk("rst_irout", ir_out, 32'd0);
        chk("rst_irpc",  {16'b0, ir_pc}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("c0_req",  {31'b0, imem_req}, 32'd1);
        chk("c0_addr", {16'b0, imem_addr}, 32'd0);
        tick();
        chk("c1_valid", {31'b0, ir_valid}, 32'd0);
        chk("c1_addr",  {16'b0, imem_addr}, 32'd1);
        tick();
        chk("c2_valid", {31'b0, ir_valid}, 32'd1);
        chk("c2_irout", ir_out, 32'h1000_0000);
        chk("c2_irpc",  {16'b0, ir_pc}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("str_valid", {31'b0, ir_valid}, 32'd1);
            chk("str_irout", ir_out, 32'h1000_0000 + k);
            chk("str_irpc",  {16'b0, ir_pc}, k);
        end

        // ---- Back-pressure: ir_ready=0 for 5 cycles after first valid ----
        ir_ready = 1'b0;
        do_reset();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_valid", {31'b0, ir_valid}, 32'd1);
            chk("stall_irout", ir_out, 32'h1000_0000);
            chk("stall_irpc",  {16'b0, ir_pc}, 32'd0);
            chk("stall_req",   {31'b0, imem_req}, 32'd0);
            if (k < 4) tick();
        end
        ir_ready = 1'b1;
        #1;
        chk("rel_req",  {31'b0, imem_req}, 32'd1);
        chk("rel_addr", {16'b0, imem_addr}, 32'd2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("rel_valid", {31'b0, ir_valid}, 32'd1);
            chk("rel_irpc",  {16'b0, ir_pc}, k);
            chk("rel_irout", ir_out, 32'h1000_0000 + k);
        end

        // ---- Redirect with a queued word and a response in flight ----
        ir_ready = 1'b0;
        do_reset();
        tick();
        tick();
        #1;
        chk("pre_rd_valid", {31'b0, ir_valid}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        ir_ready = 1'b1;
        #1;
        chk("rd_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("rd_valid1", {31'b0, ir_valid}, 32'd0);
        chk("rd_req1",   {31'b0, imem_req}, 32'd1);
        chk("rd_addr1",  {16'b0, imem_addr}, 32'h0040);
        tick();
        chk("rd_valid2", {31'b0, ir_valid}, 32'd0);
        chk("rd_addr2",  {16'b0, imem_addr}, 32'h0041);
        tick();
        chk("rd_valid3", {31'b0, ir_valid}, 32'd1);
        chk("rd_irpc3",  {16'b0, ir_pc}, 32'h0040);
        chk("rd_irout3", ir_out, 32'h1000_0040);

        // ---- PC wrap at 0xFFFF ----
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        #1;
        chk("wr_valid", {31'b0, ir_valid}, 32'd0);
        chk("wr_addr0", {16'b0, imem_addr}, 32'h0000_FFFF);
        tick();
        chk("wr_addr1", {16'b0, imem_addr}, 32'h0000_0000);
        tick();
        chk("wr_irpc0",  {16'b0, ir_pc}, 32'h0000_FFFF);
        chk("wr_irout0", ir_out, 32'h1000_FFFF);
        tick();
        chk("wr_irpc1",  {16'b0, ir_pc}, 32'h0000_0000);
        chk("wr_irout1", ir_out, 32'h1000_0000);

        // ---- Reset while a response is in flight ----
        #1;
        chk("mr_req_before", {31'b0, imem_req}, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_req_in_rst", {31'b0, imem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_valid0", {31'b0, ir_valid}, 32'd0);
        chk("mr_addr0",  {16'b0, imem_addr}, 32'd0);
        chk("mr_req0",   {31'b0, imem_req}, 32'd1);
        tick();
        chk("mr_valid1", {31'b0, ir_valid}, 32'd0);
        tick();
        chk("mr_valid2", {31'b0, ir_valid}, 32'd1);
        chk("mr_irpc2",  {16'b0, ir_pc}, 32'd0);
        chk("mr_irout2", ir_out, 32'h1000_0000);

        // ---- Halt word at address 3 ----
        halt_mode = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        #1;
`ifdef FETCH_HALT_DETECT_EN
        chk("h4_req", {31'b0, imem_req}, 32'd0);
`else
        chk("h4_req",  {31'b0, imem_req}, 32'd1);
        chk("h4_addr", {16'b0, imem_addr}, 32'd4);
`endif
        tick();
        chk("h5_irout", ir_out, 32'hF800_0000);
        chk("h5_irpc",  {16'b0, ir_pc}, 32'd3);
        tick();
`ifdef FETCH_HALT_DETECT_EN
        chk("h6_valid", {31'b0, ir_valid}, 32'd0);
        chk("h6_req",   {31'b0, imem_req}, 32'd0);
`else
        chk("h6_valid", {31'b0, ir_valid}, 32'd1);
        chk("h6_irpc",  {16'b0, ir_pc}, 32'd4);
        chk("h6_irout", ir_out, 32'h1000_0004);
`endif
        tick();
`ifdef FETCH_HALT_DETECT_EN
        chk("h7_req", {31'b0, imem_req}, 32'd0);
`endif
        redirect = 1'b1;
        redirect_pc = 16'h0008;
        tick();
        redirect = 1'b0;
        #1;
        chk("hr_req",  {31'b0, imem_req}, 32'd1);
        chk("hr_addr", {16'b0, imem_addr}, 32'd8);
        tick();
        tick();
        chk("hr_valid", {31'b0, ir_valid}, 32'd1);
        chk("hr_irpc",  {16'b0, ir_pc}, 32'd8);
        chk("hr_irout", ir_out, 32'h1000_0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
